// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
//   owner_t              : who drives the dmem port this cycle
//   STARVE_LIMIT_DEFAULT : denied host cycles before a forced steal
//   cnt_width()          : bits needed to hold 0..limit
package dmem_arb_pkg;

  typedef enum logic {OWN_CPU, OWN_HOST} owner_t;

  localparam int STARVE_LIMIT_DEFAULT = 4;

  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the MIPS MEM stage and a
// host load/debug port. The CPU has priority; an idle CPU cycle goes to a
// waiting host at once, and a host denied STARVE_LIMIT times steals one cycle
// by stalling the core.
// Ports:
//   clk, reset                           : clock, synchronous active-high reset
//   cpu_memread/memwrite/adr/wd          : MEM-stage access
//   cpu_rd, cpu_stall                    : load data, core freeze
//   host_req/we/adr/wd                   : host access request
//   host_gnt, host_rvalid, host_rdata    : grant, registered read return
//   mem_we/a/wd, mem_rd                  : dmem port
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_memread,
  input  logic        cpu_memwrite,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        cpu_stall,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [31:0] host_adr,
  input  logic [31:0] host_wd,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic [31:0] host_rdata,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam int            CW    = cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] wait_cnt, wait_cnt_d;
  logic          steal_q, steal_d;
  logic          cpu_active;
  owner_t        owner;

  always_comb begin
    cpu_active = cpu_memread | cpu_memwrite;
    owner      = OWN_CPU;
    steal_d    = 1'b0;
    wait_cnt_d = '0;
    if (!reset && host_req) begin
      if (!cpu_active) begin
        owner = OWN_HOST;
      end else if (wait_cnt == LIMIT && !steal_q) begin
        owner   = OWN_HOST;
        steal_d = 1'b1;
      end else if (steal_q) begin
        // The cycle handed back to the CPU after a steal is not counted as a
        // denial, so steals repeat every STARVE_LIMIT+2 cycles under load.
        wait_cnt_d = wait_cnt;
      end else if (wait_cnt != LIMIT) begin
        wait_cnt_d = wait_cnt + CW'(1);
      end else begin
        wait_cnt_d = wait_cnt;
      end
    end
  end

  assign host_gnt  = (owner == OWN_HOST);
  assign cpu_stall = steal_d;
  assign cpu_rd    = mem_rd;

  always_comb begin
    if (owner == OWN_HOST) begin
      mem_a  = host_adr;
      mem_wd = host_wd;
      mem_we = host_we;
    end else begin
      mem_a  = cpu_adr;
      mem_wd = cpu_wd;
      mem_we = cpu_memwrite & ~reset;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      steal_q     <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      wait_cnt    <= wait_cnt_d;
      steal_q     <= steal_d;
      host_rvalid <= host_gnt & ~host_we;
      if (host_gnt && !host_we) host_rdata <= mem_rd;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_memread, cpu_memwrite;
  logic [31:0] cpu_adr, cpu_wd, cpu_rd;
  logic        cpu_stall;
  logic        host_req, host_we;
  logic [31:0] host_adr, host_wd;
  logic        host_gnt, host_rvalid;
  logic [31:0] host_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
    .cpu_adr(cpu_adr), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_adr(host_adr), .host_wd(host_wd),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // dmem: 64 words, combinational read, synchronous write
  logic [31:0] mem [64];
  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: read data expected on host_rvalid
  always @(negedge clk) begin
    if (host_rvalid === 1'b1) begin
      if (exp_q.size() == 0) chk("rvalid_unexpected", 32'd1, 32'd0);
      else chk("host_rdata", host_rdata, exp_q.pop_front());
    end
  end

  typedef struct {
    logic cpu_rd_en, cpu_wr_en, req, we;
    logic gnt, stall, mwe, hown;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // steal sequence: CPU loads continuously, host reads 0x10 continuously
    for (int i = 0; i < 12; i++) vecs[i] = '{1, 0, 1, 0, 0, 0, 0, 0};
    vecs[4]  = '{1, 0, 1, 0, 1, 1, 0, 1};
    vecs[10] = '{1, 0, 1, 0, 1, 1, 0, 1};
    vecs[12] = '{0, 0, 1, 0, 1, 0, 0, 1};
    vecs[13] = '{0, 1, 0, 0, 0, 0, 1, 0};

    reset = 1'b1;
    cpu_memread = 0; cpu_memwrite = 0; cpu_adr = 32'h40; cpu_wd = 32'h1111;
    host_req = 1; host_we = 1; host_adr = 32'h10; host_wd = 32'h0000_00A5;

    @(negedge clk);
    chk("rst_gnt", {31'd0, host_gnt}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_rvalid", {31'd0, host_rvalid}, 32'd0);
    chk("rst_rdata", host_rdata, 32'd0);
    step();
    reset = 1'b0;

    // pending host write granted as soon as reset drops
    @(negedge clk);
    chk("wr_gnt", {31'd0, host_gnt}, 32'd1);
    chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
    chk("wr_mem_a", mem_a, 32'h10);
    chk("wr_mem_wd", mem_wd, 32'h0000_00A5);
    step();
    host_we = 0;
    @(negedge clk);
    chk("rd_gnt", {31'd0, host_gnt}, 32'd1);
    chk("rd_mem_we", {31'd0, mem_we}, 32'd0);
    exp_q.push_back(32'h0000_00A5);
    step();

    // table: starvation, steal spacing, idle grant, plain CPU store
    for (int i = 0; i < 14; i++) begin
      cpu_memread = vecs[i].cpu_rd_en; cpu_memwrite = vecs[i].cpu_wr_en;
      host_req = vecs[i].req; host_we = vecs[i].we;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), {31'd0, host_gnt}, {31'd0, vecs[i].gnt});
      chk($sformatf("v%0d_stall", i), {31'd0, cpu_stall}, {31'd0, vecs[i].stall});
      chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].mwe});
      chk($sformatf("v%0d_mem_a", i), mem_a, vecs[i].hown ? host_adr : cpu_adr);
      if (vecs[i].gnt && !vecs[i].we) exp_q.push_back(32'h0000_00A5);
      step();
    end

    // collision: CPU load 0x20 vs stealing host write 0xDEADBEEF to 0x20
    cpu_memread = 1; cpu_memwrite = 0; cpu_adr = 32'h20;
    host_req = 1; host_we = 1; host_adr = 32'h20; host_wd = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("col%0d_gnt", i), {31'd0, host_gnt}, 32'd0);
      step();
    end
    @(negedge clk);
    chk("col_steal_stall", {31'd0, cpu_stall}, 32'd1);
    chk("col_steal_mem_we", {31'd0, mem_we}, 32'd1);
    chk("col_steal_mem_a", mem_a, 32'h20);
    step();
    host_req = 0;
    @(negedge clk);
    chk("col_repeat_stall", {31'd0, cpu_stall}, 32'd0);
    chk("col_repeat_cpu_rd", cpu_rd, 32'hDEAD_BEEF);
    step();

    // reset in the middle of starvation
    cpu_adr = 32'h40;
    host_req = 1; host_we = 1; host_adr = 32'h30; host_wd = 32'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("pre%0d_gnt", i), {31'd0, host_gnt}, 32'd0);
      step();
    end
    reset = 1;
    @(negedge clk);
    chk("mid_rst_gnt", {31'd0, host_gnt}, 32'd0);
    chk("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("mid_rst_rvalid", {31'd0, host_rvalid}, 32'd0);
    step();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post%0d_gnt", i), {31'd0, host_gnt}, 32'd0);
      step();
    end
    @(negedge clk);
    chk("post_steal_gnt", {31'd0, host_gnt}, 32'd1);
    chk("post_steal_stall", {31'd0, cpu_stall}, 32'd1);
    step();
    host_req = 0; cpu_memread = 0;

    // CPU-only traffic: memory port must mirror the CPU
    for (int i = 0; i < 21; i++) begin
      if (i == 20) begin
        cpu_memread = 0; cpu_memwrite = 1; cpu_adr = 32'd84; cpu_wd = 32'd7;
      end else begin
        cpu_memread = 1'($urandom_range(0, 1));
        cpu_memwrite = 1'($urandom_range(0, 1));
        cpu_adr = 32'($urandom_range(0, 63)) << 2;
        if (cpu_adr == 32'd84) cpu_adr = 32'd88;
        cpu_wd = $urandom;
      end
      @(negedge clk);
      chk($sformatf("cpu%0d_stall", i), {31'd0, cpu_stall}, 32'd0);
      chk($sformatf("cpu%0d_mem_a", i), mem_a, cpu_adr);
      chk($sformatf("cpu%0d_mem_wd", i), mem_wd, cpu_wd);
      chk($sformatf("cpu%0d_mem_we", i), {31'd0, mem_we}, {31'd0, cpu_memwrite});
      chk($sformatf("cpu%0d_cpu_rd", i), cpu_rd, mem_rd);
      step();
    end
    cpu_memwrite = 0;

    // host reads back the final store
    host_req = 1; host_we = 0; host_adr = 32'd84;
    @(negedge clk);
    chk("final_rd_gnt", {31'd0, host_gnt}, 32'd1);
    exp_q.push_back(32'd7);
    step();
    host_req = 0;
    step();
    step();
    @(negedge clk);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
